// File: rtl/gpu_decode_pkg.sv
// rtl/gpu_decode_pkg.sv - shared types, constants and width helpers for the instruction decoder
package gpu_decode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic INST_TYPE_DRAW  = 1'b0;
    localparam logic INST_TYPE_ALPHA = 1'b1;
    localparam logic FILL_SOLID      = 1'b0;
    localparam logic FILL_TEXTURE    = 1'b1;

    localparam int DEF_COORD_W   = 16;
    localparam int DEF_MAX_VERTS = 3;
    localparam int DEF_LAYER_W   = 1;
    localparam int DEF_COLOR_W   = 24;
    localparam int DEF_TEX_W     = 2;
    localparam int DEF_ALPHA_W   = 4;

    // vsel encodes vert_count-2, never narrower than one bit
    function automatic int vsel_w(input int max_verts);
        int w;
        w = $clog2(max_verts - 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int inst_w(input int coord_w, input int max_verts, input int layer_w,
                                  input int color_w, input int tex_w, input int alpha_w);
        return 1 + vsel_w(max_verts) + max_verts * coord_w + layer_w + 1 + color_w + tex_w + alpha_w;
    endfunction

endpackage

// File: rtl/inst_field_extract.sv
// rtl/inst_field_extract.sv - combinational slicing of an instruction word into decoded fields (DECODE_ERR_CHECK_EN adds vsel_illegal)
module inst_field_extract
    import gpu_decode_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int MAX_VERTS = DEF_MAX_VERTS,
    parameter int LAYER_W   = DEF_LAYER_W,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int TEX_W     = DEF_TEX_W,
    parameter int ALPHA_W   = DEF_ALPHA_W,
    localparam int VSEL_W   = vsel_w(MAX_VERTS),
    localparam int VCNT_W   = $clog2(MAX_VERTS + 1),
    localparam int INST_W   = inst_w(COORD_W, MAX_VERTS, LAYER_W, COLOR_W, TEX_W, ALPHA_W)
) (
    input  logic [INST_W-1:0]            word,
    output logic                         inst_type,
    output logic [ALPHA_W-1:0]           alpha_set,
    output logic [MAX_VERTS*COORD_W-1:0] coordinates,
    output logic [VCNT_W-1:0]            vert_count,
    output logic [LAYER_W-1:0]           layer_num,
    output logic                         fill_type,
    output logic [COLOR_W-1:0]           color_code,
    output logic [TEX_W-1:0]             texture_code,
`ifdef DECODE_ERR_CHECK_EN
    output logic                         vsel_illegal,
`endif
    output logic [ALPHA_W-1:0]           alpha_field
);

    localparam int COORD_LSB = 1 + VSEL_W;
    localparam int LAYER_LSB = COORD_LSB + MAX_VERTS * COORD_W;
    localparam int FILL_LSB  = LAYER_LSB + LAYER_W;
    localparam int COLOR_LSB = FILL_LSB + 1;
    localparam int TEX_LSB   = COLOR_LSB + COLOR_W;
    localparam int ALPHA_LSB = TEX_LSB + TEX_W;

    logic [VSEL_W-1:0] vsel;
    logic              illegal;
    int                vcnt_raw;
    int                vcnt;

    // Slice fields, saturate the vertex count and zero unused vertices and the unused fill field
    always_comb begin
        inst_type    = word[0];
        alpha_set    = word[ALPHA_W:1];
        vsel         = word[1 +: VSEL_W];
        vcnt_raw     = int'(vsel) + 2;
        illegal      = (vcnt_raw > MAX_VERTS);
        vcnt         = illegal ? MAX_VERTS : vcnt_raw;
        vert_count   = VCNT_W'(vcnt);
        coordinates  = '0;
        for (int i = 0; i < MAX_VERTS; i++) begin
            if (i < vcnt) begin
                coordinates[(MAX_VERTS-1-i)*COORD_W +: COORD_W] = word[COORD_LSB + i*COORD_W +: COORD_W];
            end
        end
        layer_num    = word[LAYER_LSB +: LAYER_W];
        fill_type    = word[FILL_LSB];
        color_code   = (fill_type == FILL_TEXTURE) ? '0 : word[COLOR_LSB +: COLOR_W];
        texture_code = (fill_type == FILL_SOLID)   ? '0 : word[TEX_LSB +: TEX_W];
        alpha_field  = word[ALPHA_LSB +: ALPHA_W];
    end

`ifdef DECODE_ERR_CHECK_EN
    assign vsel_illegal = illegal;
`endif

endmodule

// File: rtl/inst_decode_unit.sv
// rtl/inst_decode_unit.sv - FIFO-fed registered instruction decoder with sticky alpha (DECODE_ERR_CHECK_EN adds decode_err/err_count)
module inst_decode_unit
    import gpu_decode_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int MAX_VERTS = DEF_MAX_VERTS,
    parameter int LAYER_W   = DEF_LAYER_W,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int TEX_W     = DEF_TEX_W,
    parameter int ALPHA_W   = DEF_ALPHA_W,
    localparam int VCNT_W   = $clog2(MAX_VERTS + 1),
    localparam int INST_W   = inst_w(COORD_W, MAX_VERTS, LAYER_W, COLOR_W, TEX_W, ALPHA_W)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [INST_W-1:0]            fifo_data,
    input  logic                         fifo_empty,
    output logic                         fifo_rd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MAX_VERTS*COORD_W-1:0] coordinates,
    output logic [VCNT_W-1:0]            vert_count,
    output logic [LAYER_W-1:0]           layer_num,
    output logic                         fill_type,
    output logic [COLOR_W-1:0]           color_code,
    output logic [TEX_W-1:0]             texture_code,
    output logic [ALPHA_W-1:0]           alpha_val,
`ifdef DECODE_ERR_CHECK_EN
    output logic                         decode_err,
    output logic [7:0]                   err_count,
`endif
    output logic [ALPHA_W-1:0]           global_alpha
);

    logic                         ext_inst_type;
    logic [ALPHA_W-1:0]           ext_alpha_set;
    logic [MAX_VERTS*COORD_W-1:0] ext_coord;
    logic [VCNT_W-1:0]            ext_vcnt;
    logic [LAYER_W-1:0]           ext_layer;
    logic                         ext_fill;
    logic [COLOR_W-1:0]           ext_color;
    logic [TEX_W-1:0]             ext_tex;
    logic [ALPHA_W-1:0]           ext_alpha_field;
`ifdef DECODE_ERR_CHECK_EN
    logic                         ext_vsel_illegal;
`endif

    state_t                       state_q, state_d;
    logic                         out_valid_q, out_valid_d;
    logic [MAX_VERTS*COORD_W-1:0] coord_q, coord_d;
    logic [VCNT_W-1:0]            vcnt_q, vcnt_d;
    logic [LAYER_W-1:0]           layer_q, layer_d;
    logic                         fill_q, fill_d;
    logic [COLOR_W-1:0]           color_q, color_d;
    logic [TEX_W-1:0]             tex_q, tex_d;
    logic [ALPHA_W-1:0]           alpha_val_q, alpha_val_d;
    logic [ALPHA_W-1:0]           galpha_q, galpha_d;
`ifdef DECODE_ERR_CHECK_EN
    logic                         err_q, err_d;
    logic [7:0]                   err_cnt_q, err_cnt_d;
`endif

    inst_field_extract #(
        .COORD_W   (COORD_W),
        .MAX_VERTS (MAX_VERTS),
        .LAYER_W   (LAYER_W),
        .COLOR_W   (COLOR_W),
        .TEX_W     (TEX_W),
        .ALPHA_W   (ALPHA_W)
    ) u_extract (
        .word         (fifo_data),
        .inst_type    (ext_inst_type),
        .alpha_set    (ext_alpha_set),
        .coordinates  (ext_coord),
        .vert_count   (ext_vcnt),
        .layer_num    (ext_layer),
        .fill_type    (ext_fill),
        .color_code   (ext_color),
        .texture_code (ext_tex),
`ifdef DECODE_ERR_CHECK_EN
        .vsel_illegal (ext_vsel_illegal),
`endif
        .alpha_field  (ext_alpha_field)
    );

    // Next state, pop strobe and register loads; the word is only valid in WAIT
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        coord_d     = coord_q;
        vcnt_d      = vcnt_q;
        layer_d     = layer_q;
        fill_d      = fill_q;
        color_d     = color_q;
        tex_d       = tex_q;
        alpha_val_d = alpha_val_q;
        galpha_d    = galpha_q;
        fifo_rd     = 1'b0;
`ifdef DECODE_ERR_CHECK_EN
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                fifo_rd = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ext_inst_type == INST_TYPE_ALPHA) begin
                    galpha_d = ext_alpha_set;
                    state_d  = IDLE;
                end
`ifdef DECODE_ERR_CHECK_EN
                else if (ext_vsel_illegal) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end
`endif
                else begin
                    coord_d     = ext_coord;
                    vcnt_d      = ext_vcnt;
                    layer_d     = ext_layer;
                    fill_d      = ext_fill;
                    color_d     = ext_color;
                    tex_d       = ext_tex;
                    alpha_val_d = (ext_alpha_field == '0) ? galpha_q : ext_alpha_field;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; alpha resets to opaque
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            coord_q     <= '0;
            vcnt_q      <= '0;
            layer_q     <= '0;
            fill_q      <= 1'b0;
            color_q     <= '0;
            tex_q       <= '0;
            alpha_val_q <= '0;
            galpha_q    <= '1;
`ifdef DECODE_ERR_CHECK_EN
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            coord_q     <= coord_d;
            vcnt_q      <= vcnt_d;
            layer_q     <= layer_d;
            fill_q      <= fill_d;
            color_q     <= color_d;
            tex_q       <= tex_d;
            alpha_val_q <= alpha_val_d;
            galpha_q    <= galpha_d;
`ifdef DECODE_ERR_CHECK_EN
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign out_valid    = out_valid_q;
    assign coordinates  = coord_q;
    assign vert_count   = vcnt_q;
    assign layer_num    = layer_q;
    assign fill_type    = fill_q;
    assign color_code   = color_q;
    assign texture_code = tex_q;
    assign alpha_val    = alpha_val_q;
    assign global_alpha = galpha_q;
`ifdef DECODE_ERR_CHECK_EN
    assign decode_err   = err_q;
    assign err_count    = err_cnt_q;
`endif

endmodule

// File: tb/tb_inst_decode_unit.sv
// tb/tb_inst_decode_unit.sv - scoreboard bench for inst_decode_unit at default parameters
module tb_inst_decode_unit;
    import gpu_decode_pkg::*;

    localparam int INST_W = inst_w(16, 3, 1, 24, 2, 4);

    logic              clk;
    logic              n_rst;
    logic [INST_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              out_valid;
    logic              out_ready;
    logic [47:0]       coordinates;
    logic [1:0]        vert_count;
    logic              layer_num;
    logic              fill_type;
    logic [23:0]       color_code;
    logic [1:0]        texture_code;
    logic [3:0]        alpha_val;
    logic [3:0]        global_alpha;

    typedef struct {
        logic [47:0] coords;
        logic [1:0]  vcnt;
        logic        layer;
        logic        fill;
        logic [23:0] color;
        logic [1:0]  tex;
        logic [3:0]  aval;
        logic [3:0]  galpha;
    } exp_t;

    exp_t              exp_q[$];
    int                hs_q[$];
    logic [INST_W-1:0] mem [0:15];
    int                wr_ptr = 0;
    int                rd_ptr = 0;
    int                cyc = 0;
    int                rd_cnt = 0;
    int                total = 0;
    int                bad = 0;
    logic [3:0]        model_g = 4'hF;

    inst_decode_unit dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .coordinates  (coordinates),
        .vert_count   (vert_count),
        .layer_num    (layer_num),
        .fill_type    (fill_type),
        .color_code   (color_code),
        .texture_code (texture_code),
        .alpha_val    (alpha_val),
        .global_alpha (global_alpha)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: data appears the cycle after the pop strobe
    initial fifo_data = '0;
    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [INST_W-1:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic push_alpha(input logic [3:0] a);
        logic [INST_W-1:0] w;
        w      = '1;
        w[0]   = 1'b1;
        w[4:1] = a;
        model_g = a;
        push_word(w);
    endtask

    task automatic push_draw(input logic vsel, input logic [15:0] c0, input logic [15:0] c1,
                             input logic [15:0] c2, input logic layer, input logic fill,
                             input logic [23:0] color, input logic [1:0] tex, input logic [3:0] alpha);
        logic [INST_W-1:0] w;
        exp_t e;
        w = '0;
        w[0]      = 1'b0;
        w[1]      = vsel;
        w[2+:16]  = c0;
        w[18+:16] = c1;
        w[34+:16] = c2;
        w[50]     = layer;
        w[51]     = fill;
        w[52+:24] = color;
        w[76+:2]  = tex;
        w[78+:4]  = alpha;
        e.coords = {c0, c1, (vsel ? c2 : 16'h0000)};
        e.vcnt   = vsel ? 2'd3 : 2'd2;
        e.layer  = layer;
        e.fill   = fill;
        e.color  = fill ? 24'h0 : color;
        e.tex    = fill ? tex : 2'b00;
        e.aval   = (alpha == 4'h0) ? model_g : alpha;
        e.galpha = model_g;
        exp_q.push_back(e);
        push_word(w);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check_eq("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // Monitor: protocol rule every cycle, scoreboard compare on each handshake
    always @(negedge clk) begin
        cyc++;
        if (n_rst) begin
            check_eq("rd_while_empty", 64'(fifo_rd & fifo_empty), 64'd0);
            if (fifo_rd) rd_cnt++;
            if (out_valid && out_ready) begin
                hs_q.push_back(cyc);
                check_eq("sb_empty", 64'(exp_q.size() == 0), 64'd0);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("coords", 64'(coordinates), 64'(e.coords));
                    check_eq("vcnt", 64'(vert_count), 64'(e.vcnt));
                    check_eq("layer", 64'(layer_num), 64'(e.layer));
                    check_eq("fill", 64'(fill_type), 64'(e.fill));
                    check_eq("color", 64'(color_code), 64'(e.color));
                    check_eq("tex", 64'(texture_code), 64'(e.tex));
                    check_eq("alpha_val", 64'(alpha_val), 64'(e.aval));
                    check_eq("global_alpha", 64'(global_alpha), 64'(e.galpha));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] snap_c;
        logic [23:0] snap_col;
        int          rd0;
        n_rst     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rd", 64'(fifo_rd), 64'd0);
        check_eq("rst_galpha", 64'(global_alpha), 64'hF);
        check_eq("rst_coords", 64'(coordinates), 64'd0);
        check_eq("rst_vcnt", 64'(vert_count), 64'd0);
        check_eq("rst_aval", 64'(alpha_val), 64'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Two-vertex solid draw using the reset alpha
        out_ready = 1'b1;
        push_draw(1'b0, 16'h0011, 16'h0022, 16'h0033, 1'b0, 1'b0, 24'hABCDEF, 2'b11, 4'h0);
        drain();

        // Alpha word then textured draw inheriting it: only one output
        hs_q.delete();
        push_alpha(4'h5);
        push_draw(1'b0, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b1, 24'h123456, 2'b10, 4'h0);
        drain();
        check_eq("alpha_outputs", 64'(hs_q.size()), 64'd1);
        check_eq("galpha_5", 64'(global_alpha), 64'h5);

        // Three queued draws with ready held: one per two cycles
        hs_q.delete();
        rd0 = rd_cnt;
        push_draw(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0, 24'h00FF00, 2'b01, 4'h9);
        push_draw(1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b1, 24'hFFFFFF, 2'b11, 4'h0);
        push_draw(1'b1, 16'hFFFF, 16'h0000, 16'h8001, 1'b0, 1'b0, 24'h000001, 2'b00, 4'hF);
        drain();
        check_eq("rd_pulses", 64'(rd_cnt - rd0), 64'd3);
        check_eq("hs_count", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() == 3) begin
            check_eq("spacing01", 64'(hs_q[1] - hs_q[0]), 64'd2);
            check_eq("spacing12", 64'(hs_q[2] - hs_q[1]), 64'd2);
        end

        // Back-pressure in HOLD, then back-to-back pop on ready
        out_ready = 1'b0;
        push_draw(1'b1, 16'h4444, 16'h5555, 16'h6666, 1'b1, 1'b0, 24'h0BEEF0, 2'b00, 4'h3);
        push_draw(1'b0, 16'h7777, 16'h8888, 16'h9999, 1'b0, 1'b1, 24'h0, 2'b01, 4'h0);
        wait_valid();
        snap_c   = coordinates;
        snap_col = color_code;
        repeat (5) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_no_rd", 64'(fifo_rd), 64'd0);
            check_eq("hold_coords", 64'(coordinates), 64'(snap_c));
            check_eq("hold_color", 64'(color_code), 64'(snap_col));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("b2b_rd", 64'(fifo_rd), 64'd1);
        drain();

        // Asynchronous reset while holding a draw
        out_ready = 1'b0;
        push_draw(1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 24'h777777, 2'b00, 4'h0);
        wait_valid();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        exp_q.delete();
        model_g = 4'hF;
        @(negedge clk);
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_rd", 64'(fifo_rd), 64'd0);
        check_eq("mrst_galpha", 64'(global_alpha), 64'hF);
        check_eq("mrst_coords", 64'(coordinates), 64'd0);
        @(posedge clk);
        #1;
        n_rst     = 1'b1;
        out_ready = 1'b1;
        push_draw(1'b0, 16'hCAFE, 16'hBEEF, 16'hDEAD, 1'b1, 1'b1, 24'h0, 2'b11, 4'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
